// File: rtl/weight_loader.sv
// Programs the coupling-weight array one (s, d, weight) command at a time,
// optionally reading each location back and recording readback/range errors.
module weight_loader #(
  parameter int unsigned N           = 8,
  parameter logic [7:0]  WEIGHT_MASK = 8'h40,
  parameter int unsigned READ_LAT    = 1,
  parameter logic [31:0] CMP_MASK    = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        axi_rstn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [10:0] cmd_s,
  input  logic [10:0] cmd_d,
  input  logic [31:0] cmd_wdata,
  input  logic        cmd_verify,
  output logic        wready,
  output logic [31:0] wr_addr,
  output logic [31:0] wdata,
  output logic [31:0] rd_addr,
  input  logic [31:0] rdata,
  output logic        busy,
  output logic        cmd_done,
  output logic [15:0] mismatch_cnt,
  output logic [15:0] range_err_cnt,
  output logic        err_flag,
  output logic [10:0] last_err_s,
  output logic [10:0] last_err_d
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, CHECK} state_t;

  localparam logic [3:0] LAT_INIT = 4'(READ_LAT - 1);

  state_t      state_q, state_d;
  logic        verify_q;
  logic [10:0] s_q, d_q;
  logic [3:0]  lat_q;
  logic        in_range;
  logic        accept;
  logic        range_hit;
  logic        mismatch;
  logic        done_d;

  assign in_range = (32'(cmd_s) < N) && (32'(cmd_d) < N);

  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    wready    = 1'b0;
    busy      = 1'b1;
    accept    = 1'b0;
    range_hit = 1'b0;
    mismatch  = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          accept = 1'b1;
          if (in_range) begin
            state_d = WRITE;
          end else begin
            range_hit = 1'b1;
            done_d    = 1'b1;
          end
        end
      end
      WRITE: begin
        wready = 1'b1;
        if (verify_q) begin
          state_d = READ;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      READ: begin
        if (lat_q == '0) state_d = CHECK;
      end
      CHECK: begin
        mismatch = (rdata & CMP_MASK) != (wdata & CMP_MASK);
        state_d  = IDLE;
        done_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // wr_addr/wdata load only for in-range commands so the bus lines never move
  // without a write strobe; rd_addr is held through CHECK for the combinational rdata.
  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      verify_q      <= 1'b0;
      s_q           <= '0;
      d_q           <= '0;
      lat_q         <= '0;
      wr_addr       <= '0;
      wdata         <= '0;
      rd_addr       <= '0;
      cmd_done      <= 1'b0;
      mismatch_cnt  <= '0;
      range_err_cnt <= '0;
      err_flag      <= 1'b0;
      last_err_s    <= '0;
      last_err_d    <= '0;
    end else begin
      cmd_done <= done_d;
      if (accept) begin
        s_q      <= cmd_s;
        d_q      <= cmd_d;
        verify_q <= cmd_verify;
      end
      if (accept && in_range) begin
        wr_addr <= {WEIGHT_MASK, cmd_d, cmd_s, 2'b00};
        wdata   <= cmd_wdata;
      end
      if (state_q == WRITE && verify_q) begin
        rd_addr <= wr_addr;
        lat_q   <= LAT_INIT;
      end else if (state_q == READ && lat_q != '0) begin
        lat_q <= lat_q - 4'd1;
      end
      if (range_hit) begin
        if (range_err_cnt != '1) range_err_cnt <= range_err_cnt + 16'd1;
        err_flag   <= 1'b1;
        last_err_s <= cmd_s;
        last_err_d <= cmd_d;
      end
      if (mismatch) begin
        if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + 16'd1;
        err_flag   <= 1'b1;
        last_err_s <= s_q;
        last_err_d <= d_q;
      end
    end
  end

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader: vector table of single commands, a
// back-to-back stream, and resets landing mid-command, against a matrix model.
module tb_weight_loader;

  logic        clk = 1'b0;
  logic        axi_rstn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [10:0] cmd_s, cmd_d;
  logic [31:0] cmd_wdata;
  logic        cmd_verify;
  logic        wready;
  logic [31:0] wr_addr, wdata, rd_addr, rdata;
  logic        busy, cmd_done;
  logic [15:0] mismatch_cnt, range_err_cnt;
  logic        err_flag;
  logic [10:0] last_err_s, last_err_d;

  logic        force_zero;
  logic [31:0] mem [8][8];
  logic [31:0] wr_log[$];
  logic [31:0] wa_log[$];
  int          done_cnt = 0;
  int          overlap  = 0;
  int          vec_cnt  = 0;
  int          miscmp_cnt = 0;

  always #5 clk = ~clk;

  weight_loader #(.N(8), .WEIGHT_MASK(8'h40), .READ_LAT(1), .CMP_MASK(32'hFFFF_FFFF)) dut (
    .clk(clk), .axi_rstn(axi_rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_s(cmd_s), .cmd_d(cmd_d), .cmd_wdata(cmd_wdata), .cmd_verify(cmd_verify),
    .wready(wready), .wr_addr(wr_addr), .wdata(wdata),
    .rd_addr(rd_addr), .rdata(rdata),
    .busy(busy), .cmd_done(cmd_done),
    .mismatch_cnt(mismatch_cnt), .range_err_cnt(range_err_cnt),
    .err_flag(err_flag), .last_err_s(last_err_s), .last_err_d(last_err_d)
  );

  // Matrix model, indexed [d][s] from the address fields.
  always @(posedge clk)
    if (wready && wr_addr[23:13] < 11'd8 && wr_addr[12:2] < 11'd8)
      mem[wr_addr[15:13]][wr_addr[4:2]] <= wdata;

  always_comb begin
    rdata = 32'h0;
    if (!force_zero && rd_addr[23:13] < 11'd8 && rd_addr[12:2] < 11'd8)
      rdata = mem[rd_addr[15:13]][rd_addr[4:2]];
  end

  always @(negedge clk) begin
    if (cmd_done) done_cnt++;
    if (wready) begin
      wr_log.push_back(wdata);
      wa_log.push_back(wr_addr);
    end
    if (wready && cmd_ready) overlap++;
  end

  function automatic logic [31:0] addr_of(logic [10:0] s, logic [10:0] d);
    return {8'h40, d, s, 2'b00};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issues one command from an idle DUT; lat counts cycles from acceptance to cmd_done.
  task automatic run_cmd(input logic [10:0] s, input logic [10:0] d, input logic [31:0] w,
                         input logic v, output int lat, output int writes,
                         output logic [31:0] wa, output logic [31:0] wd, output logic [31:0] ra,
                         output int ready_bad, output logic ready_at_done);
    int c;
    lat = -1; writes = 0; wa = '0; wd = '0; ra = '0; ready_bad = 0; ready_at_done = 1'b0;
    @(negedge clk);
    cmd_s = s; cmd_d = d; cmd_wdata = w; cmd_verify = v; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    c = 1;
    while (lat < 0 && c <= 30) begin
      if (wready) begin writes++; wa = wr_addr; wd = wdata; end
      if (busy && !wready) ra = rd_addr;
      if (busy && cmd_ready) ready_bad++;
      if (cmd_done) begin
        lat = c;
        ready_at_done = cmd_ready;
      end else begin
        @(posedge clk); #1;
        c++;
      end
    end
  endtask

  typedef struct {
    logic [10:0] s, d;
    logic [31:0] w;
    logic        v, fz;
    int          lat, writes;
    logic [15:0] mism, rng;
    logic        err;
    logic [10:0] ls, ld;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int lat, writes, ready_bad, base, guard;
    logic [31:0] wa, wd, ra;
    logic rad;

    //          s      d      w              v     fz    lat wr mism   rng    err   ls       ld
    tbl[0] = '{11'd3, 11'd5, 32'h0000_0012, 1'b0, 1'b0, 2, 1, 16'd0, 16'd0, 1'b0, 11'd0,    11'd0};
    tbl[1] = '{11'd3, 11'd5, 32'h0000_0012, 1'b1, 1'b0, 4, 1, 16'd0, 16'd0, 1'b0, 11'd0,    11'd0};
    tbl[2] = '{11'd1, 11'd2, 32'h0000_0007, 1'b1, 1'b1, 4, 1, 16'd1, 16'd0, 1'b1, 11'd1,    11'd2};
    tbl[3] = '{11'd8, 11'd0, 32'h0000_0099, 1'b0, 1'b0, 1, 0, 16'd1, 16'd1, 1'b1, 11'd8,    11'd0};
    tbl[4] = '{11'd0, 11'd7, 32'hAAAA_5555, 1'b1, 1'b0, 4, 1, 16'd1, 16'd1, 1'b1, 11'd8,    11'd0};
    tbl[5] = '{11'd7, 11'd7, 32'hDEAD_BEEF, 1'b0, 1'b0, 2, 1, 16'd1, 16'd1, 1'b1, 11'd8,    11'd0};
    tbl[6] = '{11'd0, 11'd8, 32'h0000_0001, 1'b1, 1'b0, 1, 0, 16'd1, 16'd2, 1'b1, 11'd0,    11'd8};
    tbl[7] = '{11'd2047, 11'd2047, 32'h1, 1'b1, 1'b0, 1, 0, 16'd1, 16'd3, 1'b1, 11'd2047, 11'd2047};
    tbl[8] = '{11'd6, 11'd6, 32'h0000_0000, 1'b1, 1'b1, 4, 1, 16'd1, 16'd3, 1'b1, 11'd2047, 11'd2047};
    tbl[9] = '{11'd4, 11'd0, 32'hFFFF_FFFF, 1'b1, 1'b1, 4, 1, 16'd2, 16'd3, 1'b1, 11'd4,    11'd0};

    axi_rstn = 1'b0; cmd_valid = 1'b0; cmd_s = '0; cmd_d = '0;
    cmd_wdata = '0; cmd_verify = 1'b0; force_zero = 1'b0;
    #2;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(cmd_done), 32'd0);
    chk("rst_wr_addr", wr_addr, 32'h0);
    chk("rst_cnts", {mismatch_cnt, range_err_cnt}, 32'h0);
    chk("rst_err", {20'(err_flag), last_err_s[5:0], last_err_d[5:0]}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) axi_rstn = 1'b1;

    for (int i = 0; i < 10; i++) begin
      force_zero = tbl[i].fz;
      run_cmd(tbl[i].s, tbl[i].d, tbl[i].w, tbl[i].v, lat, writes, wa, wd, ra, ready_bad, rad);
      force_zero = 1'b0;
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
      chk($sformatf("v%0d_writes", i), 32'(writes), 32'(tbl[i].writes));
      if (tbl[i].writes > 0) begin
        chk($sformatf("v%0d_wr_addr", i), wa, addr_of(tbl[i].s, tbl[i].d));
        chk($sformatf("v%0d_wdata", i), wd, tbl[i].w);
        if (tbl[i].v) chk($sformatf("v%0d_rd_addr", i), ra, addr_of(tbl[i].s, tbl[i].d));
      end
      chk($sformatf("v%0d_mismatch_cnt", i), 32'(mismatch_cnt), 32'(tbl[i].mism));
      chk($sformatf("v%0d_range_err_cnt", i), 32'(range_err_cnt), 32'(tbl[i].rng));
      chk($sformatf("v%0d_err_flag", i), 32'(err_flag), 32'(tbl[i].err));
      chk($sformatf("v%0d_last_err_s", i), 32'(last_err_s), 32'(tbl[i].ls));
      chk($sformatf("v%0d_last_err_d", i), 32'(last_err_d), 32'(tbl[i].ld));
      chk($sformatf("v%0d_ready_when_busy", i), 32'(ready_bad), 32'd0);
      chk($sformatf("v%0d_ready_at_done", i), 32'(rad), 32'd1);
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_one_cycle", i), 32'(cmd_done), 32'd0);
    end

    // Back-to-back stream: cmd_valid stays high, fields advance after each handshake.
    base = wr_log.size();
    lat  = done_cnt;
    overlap = 0;
    for (int i = 0; i < 16; i++) begin
      cmd_s      = (i % 2 == 1) ? 11'd7 : 11'd0;
      cmd_d      = ((i / 2) % 2 == 1) ? 11'd7 : 11'd0;
      cmd_wdata  = 32'h100 + 32'(i);
      cmd_verify = (i % 3 == 0);
      cmd_valid  = 1'b1;
      guard = 0;
      while (!cmd_ready && guard < 50) begin
        @(posedge clk); #1;
        guard++;
      end
      if (guard >= 50) chk($sformatf("stream_accept_timeout_%0d", i), 32'(guard), 32'd0);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    guard = 0;
    while (busy && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("stream_drain", 32'(busy), 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    chk("stream_writes", 32'(wr_log.size() - base), 32'd16);
    chk("stream_dones", 32'(done_cnt - lat), 32'd16);
    chk("stream_ready_in_write", 32'(overlap), 32'd0);
    for (int i = 0; i < 16 && base + i < wr_log.size(); i++) begin
      chk($sformatf("stream_wdata_%0d", i), wr_log[base + i], 32'h100 + 32'(i));
      chk($sformatf("stream_addr_%0d", i), wa_log[base + i],
          addr_of((i % 2 == 1) ? 11'd7 : 11'd0, ((i / 2) % 2 == 1) ? 11'd7 : 11'd0));
    end
    chk("weight_d0_s0", mem[0][0], 32'h10C);
    chk("weight_d0_s7", mem[0][7], 32'h10D);
    chk("weight_d7_s0", mem[7][0], 32'h10E);
    chk("weight_d7_s7", mem[7][7], 32'h10F);
    chk("stream_mismatch_cnt", 32'(mismatch_cnt), 32'd2);

    // Reset landing in READ.
    @(negedge clk);
    cmd_s = 11'd5; cmd_d = 11'd2; cmd_wdata = 32'h55; cmd_verify = 1'b1; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("rd_phase_busy", 32'(busy), 32'd1);
    chk("rd_phase_wready", 32'(wready), 32'd0);
    base = done_cnt;
    axi_rstn = 1'b0;
    #1;
    chk("rst_rd_wready", 32'(wready), 32'd0);
    chk("rst_rd_busy", 32'(busy), 32'd0);
    chk("rst_rd_done", 32'(cmd_done), 32'd0);
    chk("rst_rd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rd_cnts", {mismatch_cnt, range_err_cnt}, 32'h0);
    chk("rst_rd_err", 32'(err_flag), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) axi_rstn = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_rd_no_done", 32'(done_cnt - base), 32'd0);

    // Reset landing in WRITE drops the strobe at once.
    @(negedge clk);
    cmd_s = 11'd1; cmd_d = 11'd1; cmd_wdata = 32'h77; cmd_verify = 1'b0; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("wr_phase_wready", 32'(wready), 32'd1);
    axi_rstn = 1'b0;
    #1;
    chk("rst_wr_wready", 32'(wready), 32'd0);
    chk("rst_wr_addr", wr_addr, 32'h0);
    @(negedge clk) axi_rstn = 1'b1;

    run_cmd(11'd5, 11'd2, 32'h55, 1'b1, lat, writes, wa, wd, ra, ready_bad, rad);
    chk("post_rst_lat", 32'(lat), 32'd4);
    chk("post_rst_writes", 32'(writes), 32'd1);
    chk("post_rst_rd_addr", ra, addr_of(11'd5, 11'd2));
    chk("post_rst_weight", mem[2][5], 32'h55);
    chk("post_rst_mismatch", 32'(mismatch_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
